// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// geometry/latency and the width of the latency counter.
package mem_pkg;

  localparam int DEPTH_LOG2_DEF = 6;
  localparam int LATENCY_DEF    = 2;
  localparam int CNT_W          = 4;   // wide enough for LATENCY-1 up to 14

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered, read-first output.
// No reset: contents survive reset and are undefined after power-up.
module dmem_array #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_array [0:DEPTH-1];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[idx] <= wdata;
    end
    rdata_reg <= mem_array[idx];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one aligned word request at a
// time, waits LATENCY edges, then commits the write or returns the read data.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LATENCY    = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [31:0]           wdata_reg;
  logic                  is_write_reg;
  logic [31:0]           data_out_reg;
  logic                  mem_ready_reg;
  logic                  mem_busy_reg;
  logic                  mem_err_reg;

  logic                  req_any;
  logic                  req_aligned;
  logic                  last_wait;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [31:0]           ram_rdata;
  logic                  addr_unused;

  // Upper address bits alias onto the array and play no part in decoding.
  assign addr_unused = ^data_addr[31:DEPTH_LOG2+2];

  assign req_any     = mem_read | mem_write;
  assign req_aligned = (data_addr[1:0] == 2'b00);
  assign last_wait   = (state_reg == WAIT) && (cnt_reg == '0);

  // The RAM reads every cycle; in IDLE it is pointed at the incoming address so
  // its registered output is valid by the end of WAIT even with LATENCY=1.
  assign ram_idx = (state_reg == IDLE) ? data_addr[DEPTH_LOG2+1:2] : idx_reg;
  assign ram_we  = last_wait && is_write_reg && reset;

  dmem_array #(
    .ADDR_W(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(wdata_reg),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      wdata_reg     <= '0;
      is_write_reg  <= 1'b0;
      data_out_reg  <= '0;
      mem_ready_reg <= 1'b0;
      mem_busy_reg  <= 1'b0;
      mem_err_reg   <= 1'b0;
    end else begin
      mem_ready_reg <= 1'b0;
      mem_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            if (req_aligned) begin
              idx_reg      <= data_addr[DEPTH_LOG2+1:2];
              wdata_reg    <= data_in;
              is_write_reg <= mem_write;   // write wins when both are asserted
              cnt_reg      <= CNT_W'(LATENCY - 1);
              mem_busy_reg <= 1'b1;
              state_reg    <= WAIT;
            end else begin
              mem_err_reg  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            if (!is_write_reg) begin
              data_out_reg <= ram_rdata;
            end
            mem_ready_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RESP: begin
          mem_busy_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          mem_busy_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign mem_ready = mem_ready_reg;
  assign mem_busy  = mem_busy_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of the word count of the storage array (64 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 SHALL have port data_addr, input, 32 bits: byte address of the data access.
REQ-006 SHALL have port data_in, input, 32 bits: write data from the processor.
REQ-007 SHALL have port mem_read, input, 1 bit: read request level.
REQ-008 SHALL have port mem_write, input, 1 bit: write request level.
REQ-009 SHALL have port data_out, output, 32 bits: registered read data to the processor.
REQ-010 SHALL have port mem_ready, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port mem_busy, output, 1 bit: high while a request is in flight.
REQ-012 SHALL have port mem_err, output, 1 bit: one-cycle misaligned-access strobe.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP, with IDLE as the reset state.
REQ-014 In IDLE, a rising edge with mem_read or mem_write high and data_addr[1:0]==0 SHALL accept the request, latch the address, data and op, load the counter with LATENCY-1, and enter WAIT.
REQ-015 When mem_read and mem_write are both high at acceptance, the request SHALL be treated as a write.
REQ-016 In IDLE, a request with data_addr[1:0]!=0 SHALL NOT be accepted; mem_err SHALL be high for exactly the next cycle, and state and data_out SHALL be unchanged.
REQ-017 Word index SHALL be data_addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses alias with wrap-around modulo 4*2^DEPTH_LOG2 bytes.
REQ-018 In WAIT, each edge SHALL decrement the counter; the edge at which the counter equals 0 SHALL move to RESP.
REQ-019 A write SHALL commit to the array at the WAIT->RESP edge; a read SHALL load data_out at the same edge.
REQ-020 mem_ready SHALL be high only in RESP, for exactly one cycle; for a request accepted at edge k, mem_ready SHALL be high in the cycle after edge k+LATENCY.
REQ-021 RESP SHALL return to IDLE on the next edge unconditionally; the earliest next acceptance SHALL be edge k+LATENCY+2.
REQ-022 Request inputs SHALL be ignored in WAIT and RESP, and input changes there SHALL NOT affect the latched request.
REQ-023 mem_busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-024 data_out SHALL hold its last read value until the next read completes; writes SHALL NOT alter it.

Reset
REQ-025 With reset low at a rising edge: state SHALL become IDLE, counter 0, mem_ready 0, mem_busy 0, mem_err 0, data_out 0x00000000.
REQ-026 Reset asserted mid-operation SHALL abort the request; an uncommitted write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be cleared by reset; contents after power-up are undefined.

Structure
REQ-028 Package mem_pkg SHALL hold the state encoding (IDLE/WAIT/RESP), the DEPTH_LOG2 and LATENCY defaults, and the 4-bit counter width constant.
REQ-029 Storage SHALL be a sub-module dmem_array: a single-port synchronous RAM with write enable, word index, write data and read data.
REQ-030 The FSM, counter and request latches SHALL reside in dmem_responder.

Verification
REQ-031 Reset: hold reset=0 for 2 edges -> mem_ready=0, mem_busy=0, mem_err=0, data_out=0x00000000.
REQ-032 Write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> mem_ready high in the cycle after edge k+2 (LATENCY=2), data_out=0xDEADBEEF.
REQ-033 Wrap-around: write 0x11111111 to 0x100, then read 0x000 -> data_out=0x11111111.
REQ-034 Misaligned: read 0x13 -> mem_err high for one cycle, no mem_ready, data_out unchanged.
REQ-035 Reset mid-write: write 0x0 to 0x20; start a write of 0xA5A5A5A5 to 0x20; pull reset low during WAIT; then read 0x20 -> 0x00000000.
REQ-036 Simultaneous read and write: mem_read=mem_write=1 with 0x77777777 to 0x30 -> treated as a write, data_out unchanged; a later read of 0x30 returns 0x77777777.
